// File: rtl/htpv_pkg.sv
// Shared types and constants for the halftone stream converter.
// Optional build macro: HTPV_SERPENTINE_EN (serpentine scan, see top).
package htpv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Floyd-Steinberg weights, all divided by 2**FS_SHIFT
  localparam int FS_W_CARRY = 7;
  localparam int FS_W_DIAG  = 3;
  localparam int FS_W_BELOW = 5;
  localparam int FS_W_FAR   = 1;
  localparam int FS_SHIFT   = 4;

  function automatic int err_width(input int pixel_w);
    return pixel_w + 3;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/htpv_err_line_buf.sv
// Two ping-pong banks of per-column diffusion error: one read as the current
// row, the other accumulating contributions for the row below.
module htpv_err_line_buf
  import htpv_pkg::*;
#(
  parameter int COLS = 8,
  parameter int E    = 11,
  parameter int CW   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                swap,
  input  logic                acc_en,
  input  logic [CW-1:0]       col,
  input  logic signed [E-1:0] add_left,
  input  logic signed [E-1:0] add_mid,
  input  logic signed [E-1:0] add_right,
  output logic signed [E-1:0] cur
);

  logic signed [E-1:0] bank [2][COLS];
  logic                sel;
  logic                nsel;

  assign nsel = ~sel;
  assign cur  = bank[sel][col];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel <= 1'b0;
      for (int unsigned j = 0; j < COLS; j++) begin
        bank[0][j] <= '0;
        bank[1][j] <= '0;
      end
    end else if (clear) begin
      sel <= 1'b0;
      for (int unsigned j = 0; j < COLS; j++) begin
        bank[0][j] <= '0;
        bank[1][j] <= '0;
      end
    end else begin
      // Neighbours outside 0..COLS-1 simply never match and are dropped.
      if (acc_en) begin
        for (int unsigned j = 0; j < COLS; j++) begin
          if (j + 1 == 32'(col))
            bank[nsel][j] <= bank[nsel][j] + add_left;
          else if (j == 32'(col))
            bank[nsel][j] <= bank[nsel][j] + add_mid;
          else if (j == 32'(col) + 1)
            bank[nsel][j] <= bank[nsel][j] + add_right;
        end
      end
      if (swap) begin
        sel <= nsel;
        for (int unsigned j = 0; j < COLS; j++) begin
          bank[sel][j] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/htpv_stream_converter.sv
// Streaming Floyd-Steinberg halftone converter: one bit per pixel plus a packed row word.
// Optional build macro: HTPV_SERPENTINE_EN (odd rows scanned right to left).
module htpv_stream_converter
  import htpv_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int COLS    = 8,
  parameter int ROWS    = 6,
  parameter int THRESH  = 2 ** (PIXEL_W - 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic [PIXEL_W-1:0]         pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic                       ht_bit,
  output logic                       ht_valid,
  output logic [COLS-1:0]            row_bits,
  output logic                       row_valid,
  output logic [idx_width(ROWS)-1:0] row_index,
  output logic                       busy,
  output logic                       done
);

  localparam int E  = err_width(PIXEL_W);
  localparam int CW = idx_width(COLS);
  localparam int RW = idx_width(ROWS);

  localparam logic signed [E-1:0] MAXV     = E'((2 ** PIXEL_W) - 1);
  localparam logic signed [E-1:0] THRV     = E'(THRESH);
  localparam logic [CW-1:0]       COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0]       ROW_LAST = RW'(ROWS - 1);

  state_t              state;
  logic [RW-1:0]       row;
  logic [CW-1:0]       col;
  logic [CW-1:0]       bidx;
  logic signed [E-1:0] carry;
  logic [COLS-1:0]     row_acc;
  logic [COLS-1:0]     row_next;

  logic                accept;
  logic                rev;
  logic                rev_next;
  logic                end_row;
  logic                last_row;
  logic                hbit;
  logic                buf_clear;
  logic                buf_swap;
  logic                buf_acc;
  logic signed [E-1:0] cur;
  logic signed [E-1:0] corr;
  logic signed [E-1:0] err;
  logic signed [E+2:0] err_x;
  logic signed [E-1:0] d_carry;
  logic signed [E-1:0] d_diag;
  logic signed [E-1:0] d_below;
  logic signed [E-1:0] d_far;
  logic signed [E-1:0] add_left;
  logic signed [E-1:0] add_right;

  // Weighted error share with floor rounding (arithmetic shift of a signed product).
  function automatic logic signed [E-1:0] fs_term(input logic signed [E+2:0] e,
                                                  input int w);
    logic signed [E+2:0] prod;
    prod = e * (E+3)'(w);
    return E'(prod >>> FS_SHIFT);
  endfunction

`ifdef HTPV_SERPENTINE_EN
  assign rev      = row[0];
  assign rev_next = ~row[0];
`else
  assign rev      = 1'b0;
  assign rev_next = 1'b0;
`endif

  assign accept   = pix_valid && pix_ready;
  assign end_row  = rev ? (col == '0) : (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  assign corr  = $signed({3'b000, pix_in}) + carry + cur;
  assign hbit  = (corr >= THRV);
  assign err   = corr - (hbit ? MAXV : '0);
  assign err_x = (E+3)'(err);

  assign d_carry = fs_term(err_x, FS_W_CARRY);
  assign d_diag  = fs_term(err_x, FS_W_DIAG);
  assign d_below = fs_term(err_x, FS_W_BELOW);
  assign d_far   = fs_term(err_x, FS_W_FAR);

  // Right-to-left rows mirror the lower-row weights; the carry always feeds the next pixel.
  assign add_left  = rev ? d_far  : d_diag;
  assign add_right = rev ? d_diag : d_far;

  assign bidx = COL_LAST - col;

  always_comb begin
    row_next       = row_acc;
    row_next[bidx] = hbit;
  end

  assign buf_clear = go && (state != ST_RUN);
  assign buf_swap  = accept && end_row;
  assign buf_acc   = accept && !last_row;

  htpv_err_line_buf #(
    .COLS (COLS),
    .E    (E),
    .CW   (CW)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (buf_clear),
    .swap      (buf_swap),
    .acc_en    (buf_acc),
    .col       (col),
    .add_left  (add_left),
    .add_mid   (d_below),
    .add_right (add_right),
    .cur       (cur)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      carry     <= '0;
      row_acc   <= '0;
      pix_ready <= 1'b0;
      ht_bit    <= 1'b0;
      ht_valid  <= 1'b0;
      row_bits  <= '0;
      row_valid <= 1'b0;
      row_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ht_valid  <= 1'b0;
      row_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            state     <= ST_RUN;
            row       <= '0;
            col       <= '0;
            carry     <= '0;
            row_acc   <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            ht_bit   <= hbit;
            ht_valid <= 1'b1;
            if (end_row) begin
              carry     <= '0;
              row_acc   <= '0;
              row_bits  <= row_next;
              row_valid <= 1'b1;
              row_index <= row;
              if (last_row) begin
                state     <= ST_DONE;
                pix_ready <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                row <= row + 1'b1;
                col <= rev_next ? COL_LAST : '0;
              end
            end else begin
              carry   <= d_carry;
              row_acc <= row_next;
              col     <= rev ? col - 1'b1 : col + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/htpv_stream_converter.md
Name: htpv_stream_converter

Overview:
- Parametrised, streaming successor to the fixed 6x8 halftone image converter.
- Accepts grey-scale pixels one per cycle in scan order under a valid/ready handshake.
- Emits one halftone bit per pixel using Floyd-Steinberg error diffusion, plus a packed row word at the end of each row.
- Frame size, pixel width and threshold are parameters; sits between the image source and the halftone print/row-buffer logic.

Parameters:
- PIXEL_W, 8, pixel width in bits; full scale MAX = 2^PIXEL_W - 1.
- COLS, 8, pixels per row (minimum 2).
- ROWS, 6, rows per frame (minimum 1).
- THRESH, 2^(PIXEL_W-1), decision threshold.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  single-cycle frame start request.
- pix_in  in  PIXEL_W  unsigned input pixel.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  block accepts pix_in this cycle.
- ht_bit  out  1  halftone value of the last accepted pixel.
- ht_valid  out  1  ht_bit valid (one-cycle pulse).
- row_bits  out  COLS  packed row; row_bits[COLS-1] is column 0.
- row_valid  out  1  one-cycle pulse; row_bits complete.
- row_index  out  clog2(ROWS)  row number of row_bits.
- busy  out  1  frame in progress.
- done  out  1  frame complete; level signal.

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low.
- Reset values: all outputs 0, error buffers 0, state IDLE.
- States:
  - IDLE: on go -> RUN; clear buffers and counters.
  - RUN: pix_ready=1, busy=1. After the last accepted pixel (row ROWS-1, col COLS-1) -> DONE.
  - DONE: done=1 until go (-> RUN, done cleared the same edge) or reset.
- go in RUN is ignored. pix_valid outside RUN is ignored.
- Accept occurs when pix_valid && pix_ready. With pix_valid low, nothing advances (stall).
- Latency: ht_bit/ht_valid registered one cycle after accept. row_valid/row_bits/row_index are valid in the same cycle as the ht_valid of the last pixel in the row.
- Arithmetic: signed width E = PIXEL_W+3, no saturation required.
  - corr = pix + carry + CUR[c].
  - bit = (corr >= THRESH); err = corr - (bit ? MAX : 0).
  - Distribution, arithmetic shift (floor):
    - carry <= (7*err)>>>4.
    - NXT[c-1] += (3*err)>>>4.
    - NXT[c] += (5*err)>>>4.
    - NXT[c+1] += (1*err)>>>4.
  - Out-of-range targets are dropped. carry is cleared at end of row.
  - At end of row: CUR <= NXT, NXT <= 0 (ping-pong banks).
  - For the last row, NXT updates are discarded.
- done rises in the same cycle as the final ht_valid.
- Reset mid-frame aborts the frame. No ht_valid or row_valid is issued for the partial row.

Optional Feature:
- Macro HTPV_SERPENTINE_EN.
- Defined: odd rows are scanned right to left. Input must arrive in that order.
  - Diffusion is mirrored: 7/16 goes to c-1; 3/16 to c+1; 1/16 to c-1 below.
  - row_bits is still stored in column order.
- Undefined: all rows left to right. Logic is not compiled.

Decomposition:
- Package htpv_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - Floyd-Steinberg weight constants 7/3/5/1 and shift 4;
  - function for the error width.
- One sub-module, htpv_err_line_buf: two COLS-entry signed banks with accumulate, swap and clear ports.

Test Plan:
- Block pattern (rows 0-2 = 255x4,0x4; rows 3-5 = 0x4,255x4), default params -> row_bits 8'hF0,F0,F0,0F,0F,0F; row_index 0..5; done after the 48th ht_valid.
- Inverted block, then cross pattern, each started by go after reset pulse -> exact pixel reproduction:
  - inverted: 0F,0F,0F,F0,F0,F0.
  - cross: 3C,3C,FF,FF,3C,3C.
- Graduated rows 31,63,...,255 -> all rows end with bit 1 at column 7 and bit 0 at column 0. Total ones equal the golden-model count; bit-exact against the reference model.
- Random pix_valid stalls (about 50% duty) on the graduated pattern -> output identical to the no-stall run; no ht_valid without a prior accept.
- go pulsed during RUN -> ignored, frame completes normally. Reset asserted after pixel 20 -> all outputs 0. A new frame after go reproduces the block pattern result.
- COLS=16, ROWS=3, PIXEL_W=10, uniform 1023 -> row_bits 16'hFFFF ×3. Uniform 0 -> 16'h0000 ×3.
